phase_accumulator_8bit: RTL and testbench
=========================================

PHASE_ACCUMULATOR_8BIT -- requirements
Module: phase_accumulator_8bit

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-high.
REQ-002 The block SHALL have parameter PHASE_STEP, default 8'd1, meaning the unsigned 8-bit phase increment added per enabled cycle.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit, meaning accumulate when high and hold when low.
REQ-006 The block SHALL have port q, output, 8 bits, meaning the registered phase accumulator value.
REQ-007 The block SHALL have port wrap, output, 1 bit, present only when PHASE_ACC_WRAP_EN is defined, meaning a registered overflow pulse.

Function
REQ-008 On each rising clk edge with reset low and enable high, q SHALL become (q + PHASE_STEP) mod 256, with 8-bit unsigned arithmetic and the carry discarded from q.
REQ-009 On each rising clk edge with reset low and enable low, q SHALL hold its value.
REQ-010 Latency SHALL be one clock: the new sum is visible on q one edge after enable is sampled high; q SHALL be a direct register output with no combinational path from enable.
REQ-011 Wrap-around SHALL be seamless: 255 + 1 gives 0, and for PHASE_STEP = 3, 255 gives 2.
REQ-012 PHASE_STEP = 0 SHALL be legal; q then holds its value and no wrap is generated.
REQ-013 An enable level that is constantly low SHALL keep q at its reset value 0 indefinitely.
REQ-014 If reset and a clk edge occur together, reset SHALL dominate.

Reset
REQ-015 When reset is high, q SHALL be 8'd0 immediately, independent of clk, and wrap (if present) SHALL be 0.
REQ-016 A reset asserted in the middle of accumulation SHALL abort it.
REQ-017 After reset deasserts, accumulation SHALL restart from 0 on the first rising edge with enable high.
REQ-018 No other state SHALL exist in the block.

Configuration
REQ-019 Macro PHASE_ACC_WRAP_EN SHALL control the wrap output.
REQ-020 When PHASE_ACC_WRAP_EN is defined, the wrap port SHALL exist.
REQ-021 wrap SHALL be 1 for exactly the clock cycle following an enabled edge where q + PHASE_STEP >= 256 (carry out), and 0 otherwise, including while enable is low.
REQ-022 When PHASE_ACC_WRAP_EN is undefined, the wrap port and its logic SHALL be absent.
REQ-023 The q behaviour SHALL be identical with and without PHASE_ACC_WRAP_EN.

Verification
REQ-024 The bench SHALL cover reset hold: reset high 100 ns with 20 ns clk period and enable 0, then reset low for 25 us -> q = 0 throughout, wrap = 0.
REQ-025 The bench SHALL cover counting with PHASE_STEP = 1 and enable high after reset -> q goes 0,1,2,...,255,0, with a single one-cycle wrap pulse each time q returns to 0.
REQ-026 The bench SHALL cover a non-unit step with PHASE_STEP = 3 -> q goes 0,3,...,252,255,2,5, with wrap high only in the cycle q = 2.
REQ-027 The bench SHALL cover the hold condition: enable dropped while q = 37 for 10 cycles -> q stays 37 and wrap stays 0; after enable is raised again, q = 38 one edge later (PHASE_STEP = 1).
REQ-028 The bench SHALL cover asynchronous reset mid-count: reset pulsed between clk edges while q = 200 -> q = 0 before the next edge; counting resumes at 1 after release.
REQ-029 The bench SHALL cover the build without PHASE_ACC_WRAP_EN: compile and repeat the REQ-025 scenario -> identical q sequence, and no wrap port exists.

Source files
------------

// File: rtl/phase_accumulator_8bit.sv
// Phase accumulator: q advances by PHASE_STEP per enabled cycle, mod 256; optional wrap pulse under PHASE_ACC_WRAP_EN.
// Latency: one clock from enable to q (q is a plain register); no backpressure, enable low simply holds q.
module phase_accumulator_8bit #(
  parameter logic [7:0] PHASE_STEP = 8'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] q
`ifdef PHASE_ACC_WRAP_EN
  ,
  output logic       wrap
`endif
);

`ifdef PHASE_ACC_WRAP_EN
  // The ninth bit is the carry out that drives the wrap pulse.
  logic [8:0] sum;
  assign sum = {1'b0, q} + {1'b0, PHASE_STEP};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= 8'd0;
      wrap <= 1'b0;
    end else begin
      wrap <= enable & sum[8];
      if (enable) begin
        q <= sum[7:0];
      end
    end
  end
`else
  logic [7:0] sum;
  assign sum = q + PHASE_STEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 8'd0;
    end else if (enable) begin
      q <= sum;
    end
  end
`endif

endmodule

// File: tb/tb_phase_accumulator_8bit.sv
// Bench for phase_accumulator_8bit: step 1, 3 and 0 instances share clk/reset/enable; wrap checked when PHASE_ACC_WRAP_EN is defined.
module tb_phase_accumulator_8bit;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] q1, q3, q0;
  logic       w1, w3, w0;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] q1;
    logic [7:0] q3;
    logic [7:0] q0;
    logic       w1;
    logic       w3;
    logic       w0;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] m1, m3, m0;

  always #10 clk = ~clk;

`ifdef PHASE_ACC_WRAP_EN
  phase_accumulator_8bit #(.PHASE_STEP(8'd1)) dut1 (.clk(clk), .reset(reset), .enable(enable), .q(q1), .wrap(w1));
  phase_accumulator_8bit #(.PHASE_STEP(8'd3)) dut3 (.clk(clk), .reset(reset), .enable(enable), .q(q3), .wrap(w3));
  phase_accumulator_8bit #(.PHASE_STEP(8'd0)) dut0 (.clk(clk), .reset(reset), .enable(enable), .q(q0), .wrap(w0));
`else
  phase_accumulator_8bit #(.PHASE_STEP(8'd1)) dut1 (.clk(clk), .reset(reset), .enable(enable), .q(q1));
  phase_accumulator_8bit #(.PHASE_STEP(8'd3)) dut3 (.clk(clk), .reset(reset), .enable(enable), .q(q3));
  phase_accumulator_8bit #(.PHASE_STEP(8'd0)) dut0 (.clk(clk), .reset(reset), .enable(enable), .q(q0));
  assign w1 = 1'b0;
  assign w3 = 1'b0;
  assign w0 = 1'b0;
`endif

  // Drive one cycle: queue the reference result, then wait until just after the edge.
  task automatic drive_cycle(input logic en);
    logic [8:0] s1, s3, s0;
    exp_t x;
    enable = en;
    s1 = {1'b0, m1} + 9'd1;
    s3 = {1'b0, m3} + 9'd3;
    s0 = {1'b0, m0} + 9'd0;
    if (en) begin
      m1 = s1[7:0];
      m3 = s3[7:0];
      m0 = s0[7:0];
    end
    x.q1 = m1;
    x.q3 = m3;
    x.q0 = m0;
    x.w1 = en & s1[8];
    x.w3 = en & s3[8];
    x.w0 = en & s0[8];
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m1 = 8'd0;
    m3 = 8'd0;
    m0 = 8'd0;
    sb.delete();
  endtask

  task automatic test_reset();
    enable = 1'b0;
    reset  = 1'b1;
    m1 = 8'd0;
    m3 = 8'd0;
    m0 = 8'd0;
    #1;
    checks++;
    if ({q1, q3, q0} !== 24'd0) begin
      failures++;
      $display("FAIL reset_async_q q1=%0d q3=%0d q0=%0d required 0", q1, q3, q0);
    end
`ifdef PHASE_ACC_WRAP_EN
    checks++;
    if ({w1, w3, w0} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async_wrap got=%b required 000", {w1, w3, w0});
    end
`endif
    #99;
    reset = 1'b0;
    for (int i = 0; i < 1250; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({q1, q3, q0} !== 24'd0) begin
        failures++;
        $display("FAIL reset_hold_q cycle=%0d q1=%0d q3=%0d q0=%0d required 0", i, q1, q3, q0);
      end
`ifdef PHASE_ACC_WRAP_EN
      checks++;
      if ({w1, w3, w0} !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold_wrap cycle=%0d got=%b required 000", i, {w1, w3, w0});
      end
`endif
    end
  endtask

  task automatic test_count_step1();
    int wraps = 0;
    do_reset();
    for (int i = 1; i <= 257; i++) begin
      drive_cycle(1'b1);
      e = sb.pop_front();
      checks++;
      if (q1 !== e.q1) begin
        failures++;
        $display("FAIL count1_q cycle=%0d got=%0d required=%0d", i, q1, e.q1);
      end
`ifdef PHASE_ACC_WRAP_EN
      checks++;
      if (w1 !== e.w1) begin
        failures++;
        $display("FAIL count1_wrap cycle=%0d got=%b required=%b", i, w1, e.w1);
      end
      if (w1 === 1'b1) wraps++;
`endif
      checks++;
      if (q0 !== 8'd0 || w0 !== 1'b0) begin
        failures++;
        $display("FAIL step0_hold cycle=%0d q=%0d wrap=%b required 0/0", i, q0, w0);
      end
      if (i == 256) begin
        checks++;
        if (q1 !== 8'd0) begin
          failures++;
          $display("FAIL count1_rollover got=%0d required=0", q1);
        end
      end
    end
`ifdef PHASE_ACC_WRAP_EN
    checks++;
    if (wraps != 1) begin
      failures++;
      $display("FAIL count1_wrap_pulses got=%0d required=1", wraps);
    end
`endif
  endtask

  task automatic test_step3();
    do_reset();
    for (int i = 1; i <= 88; i++) begin
      drive_cycle(1'b1);
      e = sb.pop_front();
      checks++;
      if (q3 !== e.q3) begin
        failures++;
        $display("FAIL step3_q cycle=%0d got=%0d required=%0d", i, q3, e.q3);
      end
`ifdef PHASE_ACC_WRAP_EN
      checks++;
      if (w3 !== e.w3) begin
        failures++;
        $display("FAIL step3_wrap cycle=%0d got=%b required=%b", i, w3, e.w3);
      end
`endif
      if (i == 85 || i == 86) begin
        checks++;
        if (q3 !== ((i == 85) ? 8'd255 : 8'd2)) begin
          failures++;
          $display("FAIL step3_boundary cycle=%0d got=%0d", i, q3);
        end
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 37; i++) begin
      drive_cycle(1'b1);
      e = sb.pop_front();
    end
    checks++;
    if (q1 !== 8'd37) begin
      failures++;
      $display("FAIL hold_reach got=%0d required=37", q1);
    end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0);
      e = sb.pop_front();
      checks++;
      if (q1 !== e.q1 || q3 !== e.q3) begin
        failures++;
        $display("FAIL hold_q cycle=%0d q1=%0d q3=%0d required %0d/%0d", i, q1, q3, e.q1, e.q3);
      end
`ifdef PHASE_ACC_WRAP_EN
      checks++;
      if ({w1, w3, w0} !== 3'b000) begin
        failures++;
        $display("FAIL hold_wrap cycle=%0d got=%b required 000", i, {w1, w3, w0});
      end
`endif
    end
    drive_cycle(1'b1);
    e = sb.pop_front();
    checks++;
    if (q1 !== 8'd38 || q1 !== e.q1) begin
      failures++;
      $display("FAIL hold_resume got=%0d required=38", q1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive_cycle(1'b1);
      e = sb.pop_front();
    end
    checks++;
    if (q1 !== 8'd200) begin
      failures++;
      $display("FAIL async_reach got=%0d required=200", q1);
    end
    #8;
    reset = 1'b1;
    #2;
    checks++;
    if ({q1, q3, q0} !== 24'd0) begin
      failures++;
      $display("FAIL async_reset_q q1=%0d q3=%0d q0=%0d required 0", q1, q3, q0);
    end
`ifdef PHASE_ACC_WRAP_EN
    checks++;
    if ({w1, w3, w0} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset_wrap got=%b required 000", {w1, w3, w0});
    end
`endif
    #2;
    reset = 1'b0;
    m1 = 8'd0;
    m3 = 8'd0;
    m0 = 8'd0;
    drive_cycle(1'b1);
    e = sb.pop_front();
    checks++;
    if (q1 !== 8'd1 || q3 !== e.q3) begin
      failures++;
      $display("FAIL async_resume q1=%0d q3=%0d required 1/%0d", q1, q3, e.q3);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0));
      e = sb.pop_front();
      checks++;
      if (q1 !== e.q1 || q3 !== e.q3 || q0 !== e.q0) begin
        failures++;
        $display("FAIL b2b_q cycle=%0d got=%0d/%0d/%0d required=%0d/%0d/%0d", i, q1, q3, q0, e.q1, e.q3, e.q0);
      end
`ifdef PHASE_ACC_WRAP_EN
      checks++;
      if ({w1, w3, w0} !== {e.w1, e.w3, e.w0}) begin
        failures++;
        $display("FAIL b2b_wrap cycle=%0d got=%b required=%b", i, {w1, w3, w0}, {e.w1, e.w3, e.w0});
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_count_step1();
    test_step3();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
